fx_mac: RTL
===========

FX_MAC -- requirements
Module: fx_mac

Interface
REQ-001 Parameter Q, default 15: fractional bit count of all fixed-point operands and results.
REQ-002 Parameter N, default 32: word width; bit N-1 is sign, bits N-2:0 magnitude (sign-magnitude).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a_in  input  N  multiplicand, sign-magnitude Q format.
REQ-006 b_in  input  N  multiplier, sign-magnitude Q format.
REQ-007 in_valid  input  1  operand pair present.
REQ-008 in_last  input  1  qualifies the pair as final term of the current sum.
REQ-009 in_ready  output  1  block accepts a pair this cycle.
REQ-010 sum_out  output  N  accumulated sum, sign-magnitude Q format.
REQ-011 sum_valid  output  1  sum_out holds a completed sum.
REQ-012 sum_ready  input  1  consumer takes sum_out.
REQ-013 overflow_out  output  1  sticky overflow flag for the current sum, valid with sum_valid.

Function
REQ-014 States SHALL be IDLE, MULT, ACC, DONE.
REQ-015 IDLE: in_ready=1; on in_valid&in_ready, register a_in, b_in, in_last and go to MULT.
REQ-016 MULT: in_ready=0; register product and multiplier overflow from the fx_mult instance fed by the registered operands; go to ACC.
REQ-017 ACC: in_ready=0; add registered product into accumulator; go to DONE if registered last=1, else IDLE.
REQ-018 DONE: sum_valid=1, in_ready=0; sum_out and overflow_out SHALL stay stable until sum_valid&sum_ready, then return to IDLE.
REQ-019 Latency: sum_valid SHALL assert 3 cycles after the accepting edge of the last pair; throughput one pair per 3 cycles.
REQ-020 Accumulation: equal signs -> add magnitudes, keep sign; unequal signs -> subtract smaller magnitude from larger, take sign of larger.
REQ-021 Zero result SHALL always carry sign 0 (no negative zero).
REQ-022 Magnitude sum exceeding 2^(N-1)-1 SHALL saturate to 2^(N-1)-1, keep sign, and set overflow.
REQ-023 Multiplier overflow on any term SHALL set overflow; that term's magnitude SHALL be replaced by 2^(N-1)-1 before accumulation.
REQ-024 Accumulator and overflow SHALL clear to 0 on the DONE handshake, so the next pair starts a fresh sum.
REQ-025 Pairs presented while in_ready=0 SHALL be ignored and not consumed.

Reset
REQ-026 rst=1 SHALL force state IDLE, accumulator 0, sum_out=0, sum_valid=0, overflow_out=0, in_ready=1 on the following cycle, from any state.
REQ-027 Reset mid-sum SHALL discard all partial terms; no sum_valid SHALL be produced for them.

Structure
REQ-028 Shared package fx_pkg SHALL hold state encodings and the default Q/N constants.
REQ-029 One sub-module: the existing fx_mult, instantiated once with the same Q and N; no other sub-modules.
REQ-030 Product and overflow from fx_mult SHALL be registered before use (no combinational path into the adder).

Verification
REQ-031 Single pair 0x0000C000 x 0x00010000, last=1 -> sum_out=0x00018000, overflow_out=0, sum_valid 3 cycles after accept.
REQ-032 Pairs 0x00008000 x 0x00008000, then 0x80008000 x 0x00004000 last -> sum_out=0x00004000.
REQ-033 Pairs 0x00008000 x 0x80008000, then 0x00008000 x 0x00008000 last -> sum_out=0x00000000 (not 0x80000000).
REQ-034 Pair 0x7FFF0000 x 0x00010000 last -> overflow_out=1, sum_out=0x7FFFFFFF; next sum starts with overflow_out=0.
REQ-035 rst pulsed during MULT of second term -> outputs 0, in_ready=1 next cycle; new single pair 0x00008000 x 0x00008000 -> 0x00008000.
REQ-036 sum_ready held low 5 cycles in DONE -> sum_out, overflow_out stable, in_ready=0, in_valid pairs not consumed.

Source files
------------

// File: rtl/fx_pkg.sv
// fx_pkg: shared definitions for the fixed-point MAC slice.
//   DefQ / DefN   default fractional bit count and word width
//   mac_state_e   fx_mac controller states
package fx_pkg;

   localparam int unsigned DefQ = 15;
   localparam int unsigned DefN = 32;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMult = 2'd1,
      StAcc  = 2'd2,
      StDone = 2'd3
   } mac_state_e;

endpackage

// File: rtl/fx_mult.sv
// fx_mult: combinational sign-magnitude fixed-point multiplier.
//   a, b  operands, sign in bit N-1, Q fractional bits
//   prod  product, magnitude truncated toward zero; zero magnitude carries sign 0
//   ovf   product magnitude does not fit in N-1 bits (prod magnitude is then wrapped)
module fx_mult
   import fx_pkg::*;
#(
   parameter int unsigned Q = DefQ,
   parameter int unsigned N = DefN
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] prod,
   output logic         ovf
);

   localparam int unsigned M = N - 1;

   logic [2*M-1:0] full;
   logic [2*M-1:0] shifted;
   logic [M-1:0]   mag;

   assign full    = {{M{1'b0}}, a[M-1:0]} * {{M{1'b0}}, b[M-1:0]};
   assign shifted = full >> Q;
   assign ovf     = |shifted[2*M-1:M];
   assign mag     = shifted[M-1:0];
   assign prod    = {(a[N-1] ^ b[N-1]) & (|mag), mag};

endmodule

// File: rtl/fx_mac.sv
// fx_mac: sign-magnitude fixed-point multiply-accumulate, one pair per 3 cycles.
//   clk, rst            clock, synchronous active-high reset
//   a_in, b_in          operand pair (sign-magnitude, Q fractional bits)
//   in_valid, in_last   pair present / pair is final term of the sum
//   in_ready            pair accepted this cycle when in_valid is also high
//   sum_out, sum_valid  completed sum, held until sum_ready
//   sum_ready           consumer takes the sum
//   overflow_out        sticky overflow for the sum (saturation or multiplier overflow)
module fx_mac
   import fx_pkg::*;
#(
   parameter int unsigned Q = DefQ,
   parameter int unsigned N = DefN
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] a_in,
   input  logic [N-1:0] b_in,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   output logic [N-1:0] sum_out,
   output logic         sum_valid,
   input  logic         sum_ready,
   output logic         overflow_out
);

   localparam int unsigned M = N - 1;
   localparam logic [M-1:0] MagMax = '1;

   mac_state_e   state_q, state_d;
   logic [N-1:0] a_q, a_d, b_q, b_d;
   logic         last_q, last_d;
   logic [N-1:0] prod_q, prod_d;
   logic         prod_ovf_q, prod_ovf_d;
   logic [N-1:0] acc_q, acc_d;
   logic         ovf_q, ovf_d;

   logic [N-1:0] mult_prod;
   logic         mult_ovf;

   fx_mult #(
      .Q(Q),
      .N(N)
   ) u_mult (
      .a   (a_q),
      .b   (b_q),
      .prod(mult_prod),
      .ovf (mult_ovf)
   );

   // Sign-magnitude add of the registered term into the accumulator.
   logic [M-1:0] term_mag, acc_mag, res_mag;
   logic [M:0]   mag_sum;
   logic         term_sign, acc_sign, res_sign, add_ovf;

   always_comb begin
      term_mag  = prod_ovf_q ? MagMax : prod_q[M-1:0];
      term_sign = prod_q[N-1];
      acc_mag   = acc_q[M-1:0];
      acc_sign  = acc_q[N-1];
      mag_sum   = {1'b0, acc_mag} + {1'b0, term_mag};
      add_ovf   = 1'b0;
      if (acc_sign == term_sign) begin
         res_sign = acc_sign;
         if (mag_sum[M]) begin
            res_mag = MagMax;
            add_ovf = 1'b1;
         end else begin
            res_mag = mag_sum[M-1:0];
         end
      end else if (acc_mag >= term_mag) begin
         res_sign = acc_sign;
         res_mag  = acc_mag - term_mag;
      end else begin
         res_sign = term_sign;
         res_mag  = term_mag - acc_mag;
      end
      // Never produce negative zero.
      if (res_mag == '0) begin
         res_sign = 1'b0;
      end
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      last_d     = last_q;
      prod_d     = prod_q;
      prod_ovf_d = prod_ovf_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a_in;
               b_d     = b_in;
               last_d  = in_last;
               state_d = StMult;
            end
         end
         StMult: begin
            prod_d     = mult_prod;
            prod_ovf_d = mult_ovf;
            state_d    = StAcc;
         end
         StAcc: begin
            acc_d   = {res_sign, res_mag};
            ovf_d   = ovf_q | prod_ovf_q | add_ovf;
            state_d = last_q ? StDone : StIdle;
         end
         StDone: begin
            if (sum_ready) begin
               acc_d   = '0;
               ovf_d   = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         a_q        <= '0;
         b_q        <= '0;
         last_q     <= 1'b0;
         prod_q     <= '0;
         prod_ovf_q <= 1'b0;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         last_q     <= last_d;
         prod_q     <= prod_d;
         prod_ovf_q <= prod_ovf_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
      end
   end

   assign in_ready     = (state_q == StIdle);
   assign sum_valid    = (state_q == StDone);
   assign sum_out      = acc_q;
   assign overflow_out = ovf_q;

endmodule
